// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier engine.
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Cell behaviour select: carry-save adder, or serial two's-complement negator.
    localparam logic CELL_CSA = 1'b0;
    localparam logic CELL_NEG = 1'b1;

    function automatic int spm_cnt_w(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/spm_cell.sv
// One column of the multiplier. It holds one sum bit and one carry (or borrow) bit,
// so the column value is sum + 2*carry in CSA mode and sum - 2*borrow in NEG mode.
module spm_cell
    import spm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic mode,
    input  logic a,
    input  logic cin_chain,
    output logic sum
);

    logic carry;
    logic sum_d;
    logic carry_d;

    // In NEG mode the column absorbs -a. The borrow stays set once taken, which is
    // what keeps the running value sign-extended.
    always_comb begin
        sum_d   = 1'b0;
        carry_d = 1'b0;
        if (mode == CELL_NEG) begin
            sum_d   = a ^ carry;
            carry_d = a | carry;
        end else begin
            sum_d   = a ^ cin_chain ^ carry;
            carry_d = (a & cin_chain) | (a & carry) | (cin_chain & carry);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= 1'b0;
            carry <= 1'b0;
        end else if (clr) begin
            sum   <= 1'b0;
            carry <= 1'b0;
        end else begin
            sum   <= sum_d;
            carry <= carry_d;
        end
    end

endmodule

// File: rtl/spm_mac_seq.sv
// Serial-parallel multiplier. X is held in parallel and Y is streamed in LSB-first.
// The product leaves serially on p_bit and is also collected into p.
module spm_mac_seq
    import spm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic               p_bit,
    output logic               p_bit_vld,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // RUN   | streaming y_ext through the cell chain, cnt = 0..2*WIDTH
    // DONE  | p valid and held until out_ready

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = spm_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW);

    state_t state;
    state_t state_d;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] x_q;
    logic [PW-1:0]    y_sr;
    logic             is_signed_q;

    logic             accept;
    logic             run;
    logic             y_bit;
    logic [WIDTH-1:0] cell_a;
    logic [WIDTH-1:0] cell_sum;
    logic [WIDTH-1:0] cell_mode;
    logic [WIDTH:0]   chain_in;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign run       = (state == RUN);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and Y stream. Shifting right fills with zeros, so the last
    // RUN cycle (cnt == 2*WIDTH) feeds 0 without needing a special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_sr        <= '0;
            is_signed_q <= 1'b0;
            cnt         <= '0;
        end else if (accept) begin
            x_q         <= x;
            is_signed_q <= is_signed;
            y_sr        <= is_signed ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
            cnt         <= '0;
        end else if (run) begin
            y_sr <= y_sr >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

    assign y_bit     = run & y_sr[0];
    assign cell_a    = x_q & {WIDTH{y_bit}};
    assign chain_in  = {1'b0, cell_sum};
    assign cell_mode = {is_signed_q, {(WIDTH-1){CELL_CSA}}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        spm_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (accept),
            .mode      (cell_mode[i]),
            .a         (cell_a[i]),
            .cin_chain (chain_in[i+1]),
            .sum       (cell_sum[i])
        );
    end

    // Cell 0 holds product bit cnt-1 during each RUN cycle with cnt >= 1.
    assign p_bit     = cell_sum[0];
    assign p_bit_vld = run && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (p_bit_vld) begin
            p <= {p_bit, p[PW-1:1]};
        end
    end

endmodule

// File: tb/tb_spm_mac_seq.sv
// Randomised self-checking bench for spm_mac_seq with WIDTH=8, checked against an arithmetic product model.
module tb_spm_mac_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           is_signed;
    logic           p_bit;
    logic           p_bit_vld;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_acc = -1;

    spm_mac_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .is_signed (is_signed),
        .p_bit     (p_bit),
        .p_bit_vld (p_bit_vld),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        int ia;
        int ib;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        return (2*W)'(ia * ib);
    endfunction

    // One full transaction: offer operands, follow the serial stream, stall, release.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic sg,
                         input int stall, input bit toggle, input bit hold, input bit chk_tput);
        logic [2*W-1:0] exp;
        logic [2*W-1:0] ser;
        int n;
        int nb;
        int t_acc;
        exp       = ref_prod(xa, ya, sg);
        ser       = '0;
        nb        = 0;
        in_valid  = 1'b1;
        x         = xa;
        y         = ya;
        is_signed = sg;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("rdy_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        t_acc = cyc;
        if (chk_tput) chk("tput", t_acc - last_acc, 2*W + 3);
        last_acc = t_acc;
        if (!hold) in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            if (toggle) begin
                x         = W'($urandom);
                y         = W'($urandom);
                is_signed = 1'($urandom);
            end
            if (p_bit_vld) begin
                if (nb < 2*W) ser[nb] = p_bit;
                nb++;
            end
            @(posedge clk); #1; n++;
        end
        chk("latency", cyc - t_acc, 2*W + 1);
        chk("nbits", nb, 2*W);
        chk("p", {16'd0, p}, {16'd0, exp});
        chk("serial", {16'd0, ser}, {16'd0, exp});
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_p", {16'd0, p}, {16'd0, exp});
            chk("stall_vld", {31'd0, out_valid}, 32'd1);
            chk("stall_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {26'd0, in_ready, busy, out_valid, p_bit_vld, p_bit, 1'b0}, 32'h20);
        chk("rst_p", {16'd0, p}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'hFD, 8'h05, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_op(8'hFD, 8'h05, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_op(8'h7F, 8'h80, 1'b1, 10, 1'b0, 1'b0, 1'b0);

        // back-to-back with in_valid held, alternating mode, extreme values mixed in
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 3) begin ra = 8'h80; rb = 8'hFF; end
            if (i == 4) begin ra = 8'hFF; rb = 8'hFF; end
            do_op(ra, rb, 1'(i % 2), 0, 1'b0, 1'b1, i > 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // async reset in the middle of RUN
        in_valid  = 1'b1;
        x         = 8'hA5;
        y         = 8'h9C;
        is_signed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", {26'd0, in_ready, busy, out_valid, p_bit_vld, p_bit, 1'b0}, 32'h20);
        chk("mid_rst_p", {16'd0, p}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // operand inputs churning during RUN must not disturb the result
        for (int i = 0; i < 6; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 2, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
